voice_cmd_matcher: RTL

//  Parametrised record-and-compare engine for voice commands.
//  - RECORD: captures CHUNKS words of packed PDM samples into capture RAM.
//  - COMPARE: streams the capture against NUM_CMDS template RAMs with a per-word

---
 rtl/voice_cmd_matcher_pkg.sv | 37 +++
 rtl/voice_cmd_matcher_if.sv | 41 ++++
 rtl/voice_cmd_matcher_argmax.sv | 36 +++
 rtl/voice_cmd_matcher.sv | 136 +++++++++++++
 4 files changed

// File: rtl/voice_cmd_matcher_pkg.sv
// voice_pkg: shared types and helpers for the voice command matcher.
//   cmd_e       - game direction encoding (result values of the matcher)
//   state_e     - matcher FSM states
//   popcount()  - set-bit count of a word, zero-extended to POP_MAX_W bits
package voice_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        DOWN  = 2'd3
    } cmd_e;

    localparam int NUM_DIRS    = 4;
    localparam int SAMPLE_FREQ = 10000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECORD,
        ST_COMPARE,
        ST_DRAIN,
        ST_DECIDE
    } state_e;

    // Widest RAM word the popcount helper supports; callers zero-extend.
    localparam int POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/voice_cmd_matcher_if.sv
// voice_cmd_matcher_if: bundles the sampler stream, the shared RAM port and
// the result bus of the matcher.
//   master - the matcher: consumes samples/RAM read data, drives RAM
//            write/address and the result signals.
//   slave  - the environment (sampler, RAMs, game logic).
interface voice_cmd_matcher_if #(
    parameter int NUM_CMDS = 4,
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int CHUNKS   = 2830
) ();
    localparam int CMD_W = $clog2(NUM_CMDS);
    localparam int CNT_W = $clog2(CHUNKS + 1);

    logic                       start;
    logic                       compare_en;
    logic                       sample_valid;
    logic [WORD_W-1:0]          sample_data;
    logic                       ram_wr;
    logic [WORD_W-1:0]          ram_wdata;
    logic [ADDR_W-1:0]          ram_addr;
    logic [WORD_W-1:0]          cap_rdata;
    logic [NUM_CMDS*WORD_W-1:0] tmpl_rdata;
    logic                       busy;
    logic                       result_valid;
    logic [CMD_W-1:0]           result;
    logic                       result_hit;
    logic [CNT_W-1:0]           result_score;

    modport master (
        input  start, compare_en, sample_valid, sample_data, cap_rdata, tmpl_rdata,
        output ram_wr, ram_wdata, ram_addr, busy,
               result_valid, result, result_hit, result_score
    );

    modport slave (
        output start, compare_en, sample_valid, sample_data, cap_rdata, tmpl_rdata,
        input  ram_wr, ram_wdata, ram_addr, busy,
               result_valid, result, result_hit, result_score
    );
endinterface

// File: rtl/voice_cmd_matcher_argmax.sv
// cmd_argmax: combinational maximum over a flat array of unsigned scores.
//   scores     in   NUM_CMDS*CNT_W  score of cmd i at [i*CNT_W +: CNT_W]
//   max_score  out  CNT_W           largest score
//   max_idx    out  CMD_W           lowest index holding the largest score
//   unique_max out  1               exactly one command holds the largest score
// The tie rule lives here: a shared maximum clears unique_max.
module cmd_argmax #(
    parameter int NUM_CMDS = 4,
    parameter int CNT_W    = 4,
    localparam int CMD_W   = $clog2(NUM_CMDS)
) (
    input  logic [NUM_CMDS*CNT_W-1:0] scores,
    output logic [CNT_W-1:0]          max_score,
    output logic [CMD_W-1:0]          max_idx,
    output logic                      unique_max
);
    int n_max;

    always_comb begin
        max_score = scores[0 +: CNT_W];
        max_idx   = '0;
        for (int i = 1; i < NUM_CMDS; i++) begin
            if (scores[i*CNT_W +: CNT_W] > max_score) begin
                max_score = scores[i*CNT_W +: CNT_W];
                max_idx   = CMD_W'(i);
            end
        end
        n_max = 0;
        for (int i = 0; i < NUM_CMDS; i++) begin
            if (scores[i*CNT_W +: CNT_W] == max_score) begin
                n_max++;
            end
        end
        unique_max = (n_max == 1);
    end
endmodule

// File: rtl/voice_cmd_matcher.sv
// voice_cmd_matcher: records CHUNKS sampler words into the capture RAM, then
// optionally streams capture and all template RAMs in lockstep, scoring one
// point per word whose Hamming distance to a template is <= TOL, and reports
// the unique best command (or DEFAULT_CMD on a tie / score below MIN_SCORE).
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - voice_cmd_matcher_if.master: start/compare_en, sample stream,
//               capture write + shared RAM address, RAM read data, busy and
//               the result_valid/result/result_hit/result_score bus
module voice_cmd_matcher
    import voice_pkg::*;
#(
    parameter int          NUM_CMDS    = 4,
    parameter int          WORD_W      = 32,
    parameter int          CHUNKS      = 2830,
    parameter int          ADDR_W      = 12,
    parameter int unsigned TOL         = 0,
    parameter int unsigned MIN_SCORE   = 0,
    parameter int          DEFAULT_CMD = int'(LEFT)
) (
    input logic clk,
    input logic rst,
    voice_cmd_matcher_if.master bus
);
    localparam int CMD_W = $clog2(NUM_CMDS);
    localparam int CNT_W = $clog2(CHUNKS + 1);

    state_e                   state_reg;
    logic [ADDR_W-1:0]        cnt_reg;
    logic                     valid_d_reg;
    logic [CNT_W-1:0]         score_reg [NUM_CMDS];
    logic                     result_valid_reg;
    logic [CMD_W-1:0]         result_reg;
    logic                     result_hit_reg;
    logic [CNT_W-1:0]         result_score_reg;

    logic [NUM_CMDS-1:0]       match;
    logic [NUM_CMDS*CNT_W-1:0] score_flat;
    logic [CNT_W-1:0]          max_score;
    logic [CMD_W-1:0]          max_idx;
    logic                      unique_max;
    logic                      last_word;

    // Per-template word comparison on the read data currently presented.
    for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_cmd
        assign match[gi] = popcount(POP_MAX_W'(bus.cap_rdata ^
                               bus.tmpl_rdata[gi*WORD_W +: WORD_W])) <= TOL;
        assign score_flat[gi*CNT_W +: CNT_W] = score_reg[gi];
    end

    cmd_argmax #(
        .NUM_CMDS (NUM_CMDS),
        .CNT_W    (CNT_W)
    ) u_argmax (
        .scores     (score_flat),
        .max_score  (max_score),
        .max_idx    (max_idx),
        .unique_max (unique_max)
    );

    assign last_word = (cnt_reg == ADDR_W'(CHUNKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            valid_d_reg      <= 1'b0;
            for (int i = 0; i < NUM_CMDS; i++) score_reg[i] <= '0;
            result_valid_reg <= 1'b0;
            result_reg       <= CMD_W'(DEFAULT_CMD);
            result_hit_reg   <= 1'b0;
            result_score_reg <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            // RAM read data for the address issued last cycle arrives now.
            valid_d_reg <= (state_reg == ST_COMPARE);
            if (valid_d_reg) begin
                for (int i = 0; i < NUM_CMDS; i++) begin
                    if (match[i]) score_reg[i] <= score_reg[i] + 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt_reg <= '0;
                        for (int i = 0; i < NUM_CMDS; i++) score_reg[i] <= '0;
                        state_reg <= ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    if (bus.sample_valid) begin
                        if (last_word) begin
                            cnt_reg   <= '0;
                            state_reg <= bus.compare_en ? ST_COMPARE : ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (last_word) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_reg <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (unique_max && (32'(max_score) >= MIN_SCORE)) begin
                        result_reg     <= max_idx;
                        result_hit_reg <= 1'b1;
                    end else begin
                        result_reg     <= CMD_W'(DEFAULT_CMD);
                        result_hit_reg <= 1'b0;
                    end
                    result_score_reg <= max_score;
                    result_valid_reg <= 1'b1;
                    state_reg        <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_wr       = (state_reg == ST_RECORD) && bus.sample_valid;
    assign bus.ram_wdata    = bus.sample_data;
    assign bus.ram_addr     = cnt_reg;
    assign bus.busy         = (state_reg != ST_IDLE);
    assign bus.result_valid = result_valid_reg;
    assign bus.result       = result_reg;
    assign bus.result_hit   = result_hit_reg;
    assign bus.result_score = result_score_reg;
endmodule
